// File: rtl/decider.sv
// Decision-order store: host fills a table of {var_idx, val} entries, Control reads them in order and can rewind via back_dec_idx.
// One-cycle read latency with registered outputs. Optional `DECIDER_DONE_EN adds a registered 'done' flag (dp == wp).
module decider #(
  parameter int MAX_VARS      = 512,
  parameter int MAX_VARS_BITS = 9
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [MAX_VARS_BITS:0]   dec_config,
  input  logic                     writemem,
  input  logic                     read,
  input  logic                     write,
  input  logic [MAX_VARS_BITS-1:0] back_dec_idx,
  output logic [MAX_VARS_BITS-1:0] dec_idx_out,
  output logic [MAX_VARS_BITS-1:0] var_idx_out,
  output logic                     val_out
`ifdef DECIDER_DONE_EN
  ,
  output logic                     done
`endif
);

  typedef struct packed {
    logic [MAX_VARS_BITS-1:0] var_idx;
    logic                     val;
  } config_var_t;

  localparam logic [MAX_VARS_BITS-1:0] LAST_IDX = MAX_VARS_BITS'(MAX_VARS - 1);

  function automatic logic [MAX_VARS_BITS-1:0] ptr_inc(input logic [MAX_VARS_BITS-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  config_var_t mem [MAX_VARS];

  logic [MAX_VARS_BITS-1:0] wp_q, wp_d;
  logic [MAX_VARS_BITS-1:0] dp_q, dp_d;
  logic [MAX_VARS_BITS-1:0] dec_idx_q, dec_idx_d;
  logic [MAX_VARS_BITS-1:0] var_idx_q, var_idx_d;
  logic                     val_q, val_d;
  logic                     mem_we;
  config_var_t              rd_ent;
  config_var_t              wr_ent;

  assign wr_ent = config_var_t'(dec_config);
  assign rd_ent = mem[dp_q];

  always_comb begin
    wp_d      = wp_q;
    dp_d      = dp_q;
    dec_idx_d = dec_idx_q;
    var_idx_d = var_idx_q;
    val_d     = val_q;
    // Reset blocks the table write so a reset cycle leaves memory untouched.
    mem_we    = reset && writemem;

    if (writemem) begin
      wp_d = ptr_inc(wp_q);
    end

    if (write) begin
      dp_d = back_dec_idx;
    end else if (read) begin
      dec_idx_d = dp_q;
      var_idx_d = rd_ent.var_idx;
      val_d     = rd_ent.val;
      dp_d      = ptr_inc(dp_q);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wp_q      <= '0;
      dp_q      <= '0;
      dec_idx_q <= '0;
      var_idx_q <= '0;
      val_q     <= 1'b0;
    end else begin
      wp_q      <= wp_d;
      dp_q      <= dp_d;
      dec_idx_q <= dec_idx_d;
      var_idx_q <= var_idx_d;
      val_q     <= val_d;
    end
  end

  // Read port samples the old word, so a same-address write/read returns previous contents.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[wp_q] <= wr_ent;
    end
  end

  assign dec_idx_out = dec_idx_q;
  assign var_idx_out = var_idx_q;
  assign val_out     = val_q;

`ifdef DECIDER_DONE_EN
  logic done_q, done_d;

  always_comb begin
    done_d = (dp_d == wp_d);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign done = done_q;
`endif

endmodule

// File: tb/tb_decider.sv
// Bench for decider: directed plan followed by random traffic, every cycle compared against a table/pointer model.
module tb_decider;

  localparam int MAX_VARS = 512;
  localparam int BITS     = 9;

  logic            clock;
  logic            reset;
  logic [BITS:0]   dec_config;
  logic            writemem;
  logic            read;
  logic            write;
  logic [BITS-1:0] back_dec_idx;
  logic [BITS-1:0] dec_idx_out;
  logic [BITS-1:0] var_idx_out;
  logic            val_out;
`ifdef DECIDER_DONE_EN
  logic            done;
`endif

  decider #(.MAX_VARS(MAX_VARS), .MAX_VARS_BITS(BITS)) dut (
    .clock        (clock),
    .reset        (reset),
    .dec_config   (dec_config),
    .writemem     (writemem),
    .read         (read),
    .write        (write),
    .back_dec_idx (back_dec_idx),
    .dec_idx_out  (dec_idx_out),
    .var_idx_out  (var_idx_out),
    .val_out      (val_out)
`ifdef DECIDER_DONE_EN
    ,
    .done         (done)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: plain arrays and integer pointers.
  int m_var   [MAX_VARS];
  int m_val   [MAX_VARS];
  bit m_known [MAX_VARS];
  int m_wp, m_dp, m_dec, m_vidx, m_v, m_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycle(input bit rst_n, input bit wm, input bit rd, input bit wr,
                       input int cfg_var, input int cfg_val, input int back);
    int rd_addr;
    reset        = rst_n;
    writemem     = wm;
    read         = rd;
    write        = wr;
    dec_config   = {cfg_var[BITS-1:0], cfg_val[0]};
    back_dec_idx = back[BITS-1:0];
    @(posedge clock);
    if (!rst_n) begin
      m_wp = 0; m_dp = 0; m_dec = 0; m_vidx = 0; m_v = 0; m_done = 0;
    end else begin
      rd_addr = m_dp;
      if (wr) begin
        m_dp = back % MAX_VARS;
      end else if (rd) begin
        m_dec  = rd_addr;
        m_vidx = m_known[rd_addr] ? m_var[rd_addr] : -1;
        m_v    = m_known[rd_addr] ? m_val[rd_addr] : -1;
        m_dp   = (m_dp + 1) % MAX_VARS;
      end
      if (wm) begin
        m_var[m_wp]   = cfg_var % MAX_VARS;
        m_val[m_wp]   = cfg_val % 2;
        m_known[m_wp] = 1'b1;
        m_wp = (m_wp + 1) % MAX_VARS;
      end
      m_done = (m_dp == m_wp) ? 1 : 0;
    end
    #1;
    chk("dec_idx", 32'(dec_idx_out), 32'(m_dec));
    if (m_vidx >= 0) chk("var_idx", 32'(var_idx_out), 32'(m_vidx));
    if (m_v >= 0)    chk("val", 32'(val_out), 32'(m_v));
`ifdef DECIDER_DONE_EN
    chk("done", 32'(done), 32'(m_done));
`endif
  endtask

  task automatic do_read();
    cycle(1, 0, 1, 0, 0, 0, $urandom_range(0, 511));
  endtask

  initial begin
    int backs [4];
    for (int i = 0; i < MAX_VARS; i++) m_known[i] = 1'b0;
    m_wp = 0; m_dp = 0; m_dec = 0; m_vidx = 0; m_v = 0; m_done = 0;

    // Reset and reset-state check.
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 1, 7, 1, 33);
    chk("rst_dec", 32'(dec_idx_out), 0);
    chk("rst_var", 32'(var_idx_out), 0);
    chk("rst_val", 32'(val_out), 0);

    // Fill the whole table; outputs must stay 0.
    for (int i = 0; i < MAX_VARS; i++) cycle(1, 1, 0, 0, i, i % 2, 0);
    chk("fill_dec", 32'(dec_idx_out), 0);
    chk("fill_wp_wrapped_val", 32'(val_out), 0);

    // Sequential reads 0..3.
    for (int i = 0; i < 4; i++) do_read();
    chk("seq_dec3", 32'(dec_idx_out), 3);
    chk("seq_var3", 32'(var_idx_out), 3);
    chk("seq_val3", 32'(val_out), 1);

    // back_dec_idx ignored while write=0.
    backs = '{1, 11, 20, 409};
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 0, 0, 0, backs[i]);
    chk("ign_dec7", 32'(dec_idx_out), 7);

    // Backtracks.
    cycle(1, 0, 0, 1, 0, 0, 11);
    chk("bt_hold", 32'(dec_idx_out), 7);
    do_read();
    chk("bt11_dec", 32'(dec_idx_out), 11);
    chk("bt11_val", 32'(val_out), 1);
    cycle(1, 0, 0, 1, 0, 0, 409); do_read();
    chk("bt409_var", 32'(var_idx_out), 409);
    cycle(1, 0, 0, 1, 0, 0, 20); do_read();
    chk("bt20_val", 32'(val_out), 0);
    cycle(1, 0, 1, 1, 0, 0, 5);
    chk("wr_prio_hold", 32'(dec_idx_out), 20);
    do_read();
    chk("wr_prio_dec", 32'(dec_idx_out), 5);

    // Idle holds.
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0, 0, $urandom_range(0, 511));
    chk("idle_var", 32'(var_idx_out), 5);

    // Reset mid-stream, memory survives.
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("mid_rst_dec", 32'(dec_idx_out), 0);
    for (int i = 0; i < 4; i++) do_read();
    chk("retain_var3", 32'(var_idx_out), 3);

    // dp wrap at the top of the table.
    cycle(1, 0, 0, 1, 0, 0, MAX_VARS - 1);
    do_read();
    chk("top_dec", 32'(dec_idx_out), MAX_VARS - 1);
    do_read();
    chk("wrap_dec", 32'(dec_idx_out), 0);

    // Truncation of an oversized backtrack target (done at the model level by modulo).
    cycle(1, 0, 0, 1, 0, 0, MAX_VARS + 3); do_read();
    chk("trunc_dec", 32'(dec_idx_out), 3);

    // Same-address write and read: read returns old contents.
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 77, 0, 0);
    chk("rbw_var", 32'(var_idx_out), 0);
    chk("rbw_val", 32'(val_out), 0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 99) < 35),
            ($urandom_range(0, 99) < 55),
            ($urandom_range(0, 99) < 12),
            $urandom_range(0, 511), $urandom_range(0, 1), $urandom_range(0, 1023));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decider.md
Name: decider

Overview:
- Decision-order store for the SAT solver datapath.
- Holds a table of up to MAX_VARS decision entries. Each entry is a config_var {var_idx, val}, loaded sequentially by the host.
- Streams one entry per read request to Control, tagged with its decision index.
- Control rewinds or jumps the decision pointer via back_dec_idx when backtracking.

Parameters:
- MAX_VARS, 512, number of decision entries / table depth (`MAX_VARS).
- MAX_VARS_BITS, 9, index width, clog2(MAX_VARS) (`MAX_VARS_BITS).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- dec_config  input  config_var (MAX_VARS_BITS+1)  entry to store: var_idx, val.
- writemem  input  1  store dec_config at fill pointer, advance fill pointer.
- read  input  1  emit entry at decision pointer, advance decision pointer.
- write  input  1  load decision pointer from back_dec_idx.
- back_dec_idx  input  MAX_VARS_BITS  backtrack target index.
- dec_idx_out  output  MAX_VARS_BITS  index of entry currently presented.
- var_idx_out  output  MAX_VARS_BITS  variable index of presented entry.
- val_out  output  1  decision value of presented entry.

Behaviour:
- State:
  - MAX_VARS-deep memory of config_var.
  - fill pointer wp.
  - decision pointer dp.
  - registered outputs dec_idx_out, var_idx_out, val_out.
- Reset (reset==0 at rising edge):
  - wp=0, dp=0.
  - dec_idx_out=0, var_idx_out=0, val_out=0.
  - Memory contents are NOT cleared; they survive reset.
  - Reset overrides all other inputs in that cycle.
- writemem=1: mem[wp] <= dec_config; wp <= wp+1. Independent of read/write; may occur in the same cycle.
- write=1: dp <= back_dec_idx; outputs hold.
- write has priority over read: with write=1 and read=1 together, only the pointer load happens and the read is dropped.
- read=1 (write=0), one-cycle latency; at the edge:
  - dec_idx_out <= dp.
  - var_idx_out <= mem[dp].var_idx.
  - val_out <= mem[dp].val.
  - dp <= dp+1.
  - Outputs are valid after that edge.
- Idle (read=0, write=0): dp and all outputs hold their values indefinitely.
- back_dec_idx is ignored unless write=1.
- Wrap-around:
  - dp and wp increment modulo MAX_VARS (MAX_VARS-1 -> 0).
  - back_dec_idx >= MAX_VARS is truncated to MAX_VARS_BITS.
- writemem and read to the same address in the same cycle: the read returns the old contents (read-before-write).
- Entries never written read as undefined. Zero-initialising memory in simulation is permitted but not required.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: DECIDER_DONE_EN.
- Defined:
  - Adds output port done (1 bit, registered, reset 0).
  - done=1 when dp == wp after any update, i.e. all loaded decisions consumed and none pending.
  - A write that moves dp below wp clears done.
  - Computed as the next-state compare, so it is valid the cycle after the pointer change.
- Undefined: port absent; no extra logic.

Test Plan:
- Fill: after reset, writemem=1 for MAX_VARS cycles with entry i = {var_idx=i, val=i[0]} -> wp wraps to 0; outputs stay 0.
- Sequential read: read=1 for 4 cycles -> outputs (dec,var,val) = (0,0,0), (1,1,1), (2,2,0), (3,3,1) on successive edges.
- Read ignores back_dec_idx: continue read=1 with back_dec_idx=1,11,20,409, write=0 -> outputs continue 4..7.
- Backtrack:
  - write=1 back_dec_idx=11, then read=1 -> dec_idx_out=11, var_idx_out=11, val_out=1.
  - Repeat with 409 -> 409/409/1.
  - Repeat with 20 -> 20/20/0.
  - write+read same cycle with back_dec_idx=5, then read -> outputs 5/5/1.
- Idle: read=0, write=0 for 4 cycles -> all outputs unchanged.
- Reset mid-stream:
  - Pulse reset=0 for one cycle -> outputs 0.
  - Then read=1 -> 0,1,2,3 with stored values intact, proving memory retention.
  - Read at dp=MAX_VARS-1 -> next read returns index 0.
